// File: rtl/uart_resp_tx.sv
// uart_resp_tx: sends 0x55, code, seq, [crc8], 0xAA response frames on an 8N1 UART line.
// Define RESP_CRC_EN for the 5-byte frame with CRC8; the default build sends the 4-byte frame.
module uart_resp_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       resp_start,
    input  logic [7:0] resp_code,
    output logic       uart_txd,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       resp_drop,
    output logic [7:0] seq_num
);
    // state | meaning
    // IDLE  | line idle, waiting for a request or a pending code
    // LOAD  | latch seq (and crc), advance seq_num
    // START | start bit
    // DATA  | 8 data bits, LSB first
    // STOP  | stop bit; at its end either next byte (START) or DONE
    // DONE  | completion pulse; can launch the next frame directly
    // sys_rst_n is active-high despite its name.

    localparam int          BPS_CNT  = CLK_FREQ / UART_BPS;
    localparam logic [15:0] BIT_LAST = 16'(BPS_CNT - 1);
`ifdef RESP_CRC_EN
    localparam logic [2:0]  LAST_BYTE = 3'd4;
`else
    localparam logic [2:0]  LAST_BYTE = 3'd3;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t      state, state_n;
    logic [15:0] bit_cnt, bit_cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [2:0]  byte_idx, byte_idx_n;
    logic [7:0]  code_q;
    logic [7:0]  seq_q;
    logic        pend_valid;
    logic [7:0]  pend_code;
    logic        launch;
    logic        bit_end;
    logic        txd_n;
    logic        busy_n;
    logic [7:0]  cur_byte;

    assign bit_end = (bit_cnt == BIT_LAST);

`ifdef RESP_CRC_EN
    logic [7:0] crc_q;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    // crc is ready in LOAD, long before byte 3 starts
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n)
            crc_q <= 8'h00;
        else if (state == S_LOAD)
            crc_q <= crc8_byte(crc8_byte(8'h00, code_q), seq_num);
    end
`endif

    always_comb begin
        cur_byte = 8'hAA;
        case (byte_idx_n)
            3'd0:    cur_byte = 8'h55;
            3'd1:    cur_byte = code_q;
            3'd2:    cur_byte = seq_q;
`ifdef RESP_CRC_EN
            3'd3:    cur_byte = crc_q;
`endif
            default: cur_byte = 8'hAA;
        endcase
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = 16'd0;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        launch     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (pend_valid || resp_start) begin
                    state_n = S_LOAD;
                    launch  = 1'b1;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_LOAD: begin
                state_n    = S_START;
                byte_idx_n = 3'd0;
            end
            S_START: begin
                bit_idx_n = 3'd0;
                if (bit_end)
                    state_n = S_DATA;
                else
                    bit_cnt_n = bit_cnt + 16'd1;
            end
            S_DATA: begin
                if (bit_end) begin
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        state_n = S_STOP;
                end else begin
                    bit_cnt_n = bit_cnt + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (byte_idx == LAST_BYTE) begin
                        state_n = S_DONE;
                    end else begin
                        byte_idx_n = byte_idx + 3'd1;
                        state_n    = S_START;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 16'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // line level registered from the next state so uart_txd never glitches
    always_comb begin
        txd_n  = 1'b1;
        busy_n = (state_n == S_START) || (state_n == S_DATA) || (state_n == S_STOP);
        if (state_n == S_START)
            txd_n = 1'b0;
        else if (state_n == S_DATA)
            txd_n = cur_byte[bit_idx_n];
    end

    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            state      <= S_IDLE;
            bit_cnt    <= 16'd0;
            bit_idx    <= 3'd0;
            byte_idx   <= 3'd0;
            code_q     <= 8'h00;
            seq_q      <= 8'h00;
            seq_num    <= 8'h00;
            pend_valid <= 1'b0;
            pend_code  <= 8'h00;
            uart_txd   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            resp_drop  <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            bit_idx   <= bit_idx_n;
            byte_idx  <= byte_idx_n;
            uart_txd  <= txd_n;
            tx_busy   <= busy_n;
            tx_done   <= (state_n == S_DONE);
            resp_drop <= 1'b0;

            if (state == S_LOAD) begin
                seq_q   <= seq_num;
                seq_num <= seq_num + 8'd1;
            end

            // pending code wins a launch; a simultaneous request takes the freed slot
            if (launch) begin
                code_q <= pend_valid ? pend_code : resp_code;
                if (pend_valid) begin
                    pend_valid <= resp_start;
                    if (resp_start)
                        pend_code <= resp_code;
                end
            end else if (resp_start) begin
                pend_code  <= resp_code;
                pend_valid <= 1'b1;
                resp_drop  <= pend_valid;
            end
        end
    end

endmodule
